// File: rtl/sort4_pkg.sv
// rtl/sort4_pkg.sv - shared state encoding and compare-exchange step table for sort4_seq
package sort4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NSTEPS = 5;

    // One nibble per step, step 0 in the low nibble: {lo_index, hi_index}.
    // Order (0,1), (2,3), (0,2), (1,3), (1,2).
    localparam logic [4*NSTEPS-1:0] STEP_PAIRS = {
        4'b01_10,
        4'b01_11,
        4'b00_10,
        4'b10_11,
        4'b00_01
    };

    function automatic logic [3:0] step_pair(input logic [2:0] step);
        return STEP_PAIRS[4*int'(step) +: 4];
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// rtl/cmp_swap.sv - combinational compare-exchange; swaps only when x is strictly greater than y
module cmp_swap #(
    parameter int W = 2
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swapped
);

    assign swapped = (x > y);
    assign lo      = swapped ? y : x;
    assign hi      = swapped ? x : y;

endmodule

// File: rtl/sort4_seq.sv
// rtl/sort4_seq.sv - sequential 4-element sorter, one shared compare-exchange per cycle
// Optional swap counter port enabled by defining SORT4_SWAPCNT_EN.
module sort4_seq
    import sort4_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] min,
    output logic [W-1:0] midl,
    output logic [W-1:0] midh,
    output logic [W-1:0] max
`ifdef SORT4_SWAPCNT_EN
    ,
    output logic [2:0]   swap_cnt
`endif
);

    state_t       state;
    state_t       state_nxt;
    logic [2:0]   step;
    logic [W-1:0] work     [4];
    logic [W-1:0] work_nxt [4];
    logic [W-1:0] res      [4];
    logic [3:0]   pair;
    logic [1:0]   lo_idx;
    logic [1:0]   hi_idx;
    logic [W-1:0] cs_lo;
    logic [W-1:0] cs_hi;
    logic         cs_swapped;
    logic         accept;
    logic         last_step;

    assign pair      = step_pair(step);
    assign lo_idx    = pair[3:2];
    assign hi_idx    = pair[1:0];
    assign last_step = (step == 3'(NSTEPS - 1));

    cmp_swap #(.W(W)) u_cmp_swap (
        .x       (work[lo_idx]),
        .y       (work[hi_idx]),
        .lo      (cs_lo),
        .hi      (cs_hi),
        .swapped (cs_swapped)
    );

    always_comb begin
        work_nxt         = work;
        work_nxt[lo_idx] = cs_lo;
        work_nxt[hi_idx] = cs_hi;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SORT;
            end
            SORT: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? SORT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        accept = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Result registers load only on the last step, so they survive the next sort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                work[i] <= '0;
                res[i]  <= '0;
            end
        end else if (accept) begin
            step    <= 3'd0;
            work[0] <= a;
            work[1] <= b;
            work[2] <= c;
            work[3] <= d;
        end else if (state == SORT) begin
            work <= work_nxt;
            step <= last_step ? 3'd0 : step + 3'd1;
            if (last_step) res <= work_nxt;
        end
    end

    assign min  = res[0];
    assign midl = res[1];
    assign midh = res[2];
    assign max  = res[3];

`ifdef SORT4_SWAPCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              swap_cnt <= 3'd0;
        else if (accept)                      swap_cnt <= 3'd0;
        else if (state == SORT && cs_swapped) swap_cnt <= swap_cnt + 3'd1;
    end
`endif

endmodule

// File: doc/sort4_seq.md
SORT4_SEQ -- requirements
Module: sort4_seq

Interface
REQ-001 Parameter: W, default 2, element width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  a/b/c/d carry a new set to sort.
REQ-005 in_ready  output  1  block can accept a set this cycle.
REQ-006 a, b, c, d  input  W each  unsorted elements, indices 0..3.
REQ-007 out_valid  output  1  min/midl/midh/max hold a finished result.
REQ-008 out_ready  input  1  consumer accepts the result this cycle.
REQ-009 min, midl, midh, max  output  W each  sorted result, ascending.
REQ-010 swap_cnt  output  3  swaps made by the last sort; present only with SORT4_SWAPCNT_EN.

Function
REQ-011 The block SHALL sort four unsigned W-bit elements with one shared compare-exchange unit, one compare-exchange step per cycle.
- Fixed step order: (0,1), (2,3), (0,2), (1,3), (1,2).
REQ-012 Compare-exchange SHALL swap only when the lower-index element is strictly greater; equal elements are not swapped.
REQ-013 FSM states SHALL be IDLE, SORT, DONE.
- IDLE->SORT on accept.
- SORT holds for 5 cycles; step counter 0..4; SORT->DONE after step 4.
- DONE->IDLE on out_ready without a new accept.
- DONE->SORT on out_ready with a same-cycle accept.
REQ-014 in_ready SHALL be 1 in IDLE, and (out_ready) in DONE; 0 in SORT.
REQ-015 Accept = in_valid && in_ready at a rising edge; a..d SHALL be sampled only at accept and ignored otherwise.
REQ-016 Latency: accept at edge k, steps at edges k+1..k+5, out_valid high after edge k+5.
REQ-017 out_valid SHALL be 1 exactly in DONE; result outputs SHALL hold stable while out_valid=1 && out_ready=0.
REQ-018 Result outputs SHALL retain the last result after handshake until the next DONE; they are not required meaningful while out_valid=0.
REQ-019 Back-to-back: DONE with out_ready=1 and in_valid=1 SHALL complete the output handshake and load the new set in the same edge; no idle bubble.
REQ-020 in_valid during SORT SHALL be ignored (in_ready=0); the producer holds the set.

Reset
REQ-021 rst=1 SHALL immediately force IDLE, step counter 0, working registers 0, out_valid 0, in_ready 1, min/midl/midh/max 0, swap_cnt 0.
REQ-022 rst asserted mid-SORT or in DONE SHALL abandon the set; no result is ever presented for it.
REQ-023 First accept is possible on the first rising edge after rst deasserts.

Configuration
REQ-024 Macro SORT4_SWAPCNT_EN defined: swap_cnt port exists, cleared on accept, +1 per actual swap, final value valid with out_valid (range 0..5).
REQ-025 Macro undefined: no swap_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-026 Package sort4_pkg SHALL hold: state enum (IDLE, SORT, DONE), NSTEPS=5, and the step-to-index-pair table.
REQ-027 One sub-module cmp_swap (combinational: two W-bit in, lo/hi out, swapped flag) SHALL be instantiated once and muxed per step.

Verification
REQ-028 a=3,b=0,c=2,d=1 accepted at edge k -> out_valid after edge k+5, outputs 0,1,2,3, swap_cnt=4.
REQ-029 a=b=c=d=2 -> outputs 2,2,2,2, swap_cnt=0; 0,1,2,3 -> 0,1,2,3, swap_cnt=0.
REQ-030 a=3,b=2,c=1,d=0 with out_ready=0 for 4 cycles -> outputs 0,1,2,3 stable, in_ready=0 throughout, then handshake -> IDLE.
REQ-031 DONE with out_ready=1 and in_valid=1 carrying 1,3,0,2 -> new set accepted same edge, next result 0,1,2,3 exactly 5 cycles later.
REQ-032 rst pulsed at SORT step 2 -> outputs 0, out_valid 0, in_ready 1 immediately; next set 2,0,3,1 sorts to 0,1,2,3.
REQ-033 Change a..d during SORT -> result unaffected.
